// File: rtl/fifo_occ_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_occ_ctrl
//   Small first-word-fall-through FIFO that sits directly upstream of a 4-bit
//   occupancy counter. Every cycle it produces the counter's increment and
//   decrement strobes. It also keeps its own pointers, state and count, so
//   full/empty never have to wait on the counter. The local count tracks the
//   counter's par_out cycle for cycle.
//
//   Handshake: a transfer happens on a port in any cycle where valid and ready
//   are both 1 at the rising edge. push = wr_valid & wr_ready and
//   pop = rd_valid & rd_ready. Ready and valid never depend on the other
//   side's valid or ready within the same port, so there are no
//   combinational loops.
//
// Parameters
//   DATA_W : width of each stored word
//   DEPTH  : number of entries, 2..15, so the count fits in 4 bits
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   wr_valid     in   producer offers wr_data
//   wr_ready     out  FIFO can accept a word (= ~full)
//   wr_data      in   word to push
//   rd_valid     out  rd_data holds the oldest word (= ~empty)
//   rd_ready     in   consumer takes rd_data
//   rd_data      out  head word, 0 when empty
//   up_cnt_en    out  occupancy counter increment strobe
//   down_cnt_en  out  occupancy counter decrement strobe
//   count        out  number of stored entries, 0..DEPTH
//   full         out  count == DEPTH
//   empty        out  count == 0
//   ovf_err      out  sticky protocol-error flag (only when FIFO_OVF_FLAG_EN
//                     is defined)
//   state_dbg    out  raw FSM state encoding, for observation
//
// Build option
//   FIFO_OVF_FLAG_EN : when defined, adds ovf_err. It is set after any cycle
//                      with a write offered while full, or a read requested
//                      while empty. Only reset clears it.
// -----------------------------------------------------------------------------
module fifo_occ_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              up_cnt_en,
    output logic              down_cnt_en,
    output logic [3:0]        count,
    output logic              full,
    output logic              empty,
`ifdef FIFO_OVF_FLAG_EN
    output logic              ovf_err,
`endif
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_PART  = 2'b01,
        S_FULL  = 2'b10
    } state_t;

    localparam logic [3:0] LAST_PTR  = 4'(DEPTH - 1);
    localparam logic [3:0] ALMOST_FULL = 4'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [3:0]        wr_ptr;
    logic [3:0]        rd_ptr;
    state_t            state;
    state_t            next_state;
    logic              push;
    logic              pop;

    // Handshake qualifiers and counter strobes. A simultaneous push and pop
    // leaves the occupancy unchanged, so neither strobe fires.
    assign push        = wr_valid & wr_ready;
    assign pop         = rd_valid & rd_ready;
    assign up_cnt_en   = push & ~pop;
    assign down_cnt_en = pop & ~push;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // The depth need not be a power of two, so the pointers wrap explicitly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? 4'd0 : wr_ptr + 4'd1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? 4'd0 : rd_ptr + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (up_cnt_en) begin
            count <= count + 4'd1;
        end else if (down_cnt_en) begin
            count <= count - 4'd1;
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state. The transitions are decided from the count before the
    // edge, so crossing into FULL or EMPTY happens in the same edge that the
    // count reaches DEPTH or 0.
    always_comb begin
        next_state = state;
        case (state)
            S_EMPTY: begin
                if (push) begin
                    next_state = S_PART;
                end
            end
            S_PART: begin
                if (up_cnt_en && (count == ALMOST_FULL)) begin
                    next_state = S_FULL;
                end else if (down_cnt_en && (count == 4'd1)) begin
                    next_state = S_EMPTY;
                end
            end
            S_FULL: begin
                if (pop) begin
                    next_state = S_PART;
                end
            end
            default: next_state = S_EMPTY;  // recover from 2'b11
        endcase
    end

    // FSM: outputs
    always_comb begin
        empty     = (state == S_EMPTY);
        full      = (state == S_FULL);
        wr_ready  = ~full;
        rd_valid  = ~empty;
        rd_data   = rd_valid ? mem[rd_ptr] : '0;
        state_dbg = state;
    end

`ifdef FIFO_OVF_FLAG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_err <= 1'b0;
        end else if ((wr_valid & full) | (rd_ready & empty)) begin
            ovf_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_occ_ctrl.sv
module tb_fifo_occ_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 15;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic              up_cnt_en;
  logic              down_cnt_en;
  logic [3:0]        count;
  logic              full;
  logic              empty;
  logic [1:0]        state_dbg;
`ifdef FIFO_OVF_FLAG_EN
  logic              ovf_err;
  logic              exp_ovf;
`endif

  always #5 clk = ~clk;

  fifo_occ_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_data     (wr_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .rd_data     (rd_data),
    .up_cnt_en   (up_cnt_en),
    .down_cnt_en (down_cnt_en),
    .count       (count),
    .full        (full),
    .empty       (empty),
`ifdef FIFO_OVF_FLAG_EN
    .ovf_err     (ovf_err),
`endif
    .state_dbg   (state_dbg)
  );

  // ---------------- scoreboard ----------------
  logic [DATA_W-1:0] exp_q[$];
  logic [3:0]        ctr_model;   // occupancy counter driven by the strobes
  int                n_tests = 0;
  int                n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_values();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_up", 32'(up_cnt_en), 32'd0);
    check("rst_down", 32'(down_cnt_en), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
`ifdef FIFO_OVF_FLAG_EN
    check("rst_ovf", 32'(ovf_err), 32'd0);
`endif
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs after the falling edge, check every output
  // against the model, then let the rising edge commit and update the model.
  task automatic cycle(input logic wv, input logic [DATA_W-1:0] wd, input logic rr);
    int  sz;
    logic exp_push, exp_pop;
    logic [1:0] exp_state;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
    sz        = exp_q.size();
    exp_push  = wv && (sz != DEPTH);
    exp_pop   = rr && (sz != 0);
    exp_state = (sz == 0) ? 2'd0 : (sz == DEPTH) ? 2'd2 : 2'd1;
    check("count", 32'(count), 32'(sz));
    check("count_vs_ctr", 32'(count), 32'(ctr_model));
    check("empty", 32'(empty), 32'(sz == 0));
    check("full", 32'(full), 32'(sz == DEPTH));
    check("wr_ready", 32'(wr_ready), 32'(sz != DEPTH));
    check("rd_valid", 32'(rd_valid), 32'(sz != 0));
    check("rd_data", 32'(rd_data), (sz == 0) ? 32'd0 : 32'(exp_q[0]));
    check("up_cnt_en", 32'(up_cnt_en), 32'(exp_push && !exp_pop));
    check("down_cnt_en", 32'(down_cnt_en), 32'(exp_pop && !exp_push));
    check("state", 32'(state_dbg), 32'(exp_state));
`ifdef FIFO_OVF_FLAG_EN
    check("ovf_err", 32'(ovf_err), 32'(exp_ovf));
    if ((wv && sz == DEPTH) || (rr && sz == 0)) exp_ovf = 1'b1;
`endif
    if (up_cnt_en)   ctr_model = ctr_model + 4'd1;
    if (down_cnt_en) ctr_model = ctr_model - 4'd1;
    @(posedge clk);
    if (exp_pop)  void'(exp_q.pop_front());
    if (exp_push) exp_q.push_back(wd);
  endtask

  // ---------------- stimulus ----------------
  logic [DATA_W-1:0] t1_data [3];

  initial begin
    t1_data[0] = 8'h11;
    t1_data[1] = 8'h22;
    t1_data[2] = 8'h33;
    ctr_model = 4'd0;
`ifdef FIFO_OVF_FLAG_EN
    exp_ovf = 1'b0;
`endif
    rst      = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: three pushes, no reads
    for (int i = 0; i < 3; i++) cycle(1'b1, t1_data[i], 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t1_count", 32'(count), 32'd3);
    check("t1_head", 32'(rd_data), 32'h11);

    // Test 2: fill to 15, then one refused write
    for (int i = 3; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
    cycle(1'b1, 8'hEE, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t2_full", 32'(full), 32'd1);
    check("t2_wr_ready", 32'(wr_ready), 32'd0);
    check("t2_count", 32'(count), 32'd15);

    // Test 3: drain in order, then a read request while empty
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t3_empty", 32'(empty), 32'd1);
    check("t3_rd_data", 32'(rd_data), 32'd0);

    // Test 4: hold five entries with simultaneous push and pop, pointers wrap
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'hA0 + i), 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    check("t4_count", 32'(count), 32'd5);
    check("t4_head", 32'(rd_data), 32'hAF);

    // Test 5: asynchronous reset in mid-cycle at count 7
    cycle(1'b1, 8'h51, 1'b0);
    cycle(1'b1, 8'h52, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t5_pre_count", 32'(count), 32'd7);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_reset_values();
    exp_q.delete();
    ctr_model = 4'd0;
`ifdef FIFO_OVF_FLAG_EN
    exp_ovf = 1'b0;
`endif
    @(negedge clk);
    rst = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    cycle(1'b1, 8'h61, 1'b0);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);

`ifdef FIFO_OVF_FLAG_EN
    // Test 6: write offered while full sets the sticky flag
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t6_ovf_clear", 32'(ovf_err), 32'd0);
    cycle(1'b1, 8'hFF, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t6_ovf_set", 32'(ovf_err), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1);
    check("t6_ovf_sticky", 32'(ovf_err), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
